htar9_mc: RTL and testbench
===========================

# htar9_mc

Parametrised multicycle htar9 core. It replaces the fixed single-cycle top with one that has configurable data, PC and register-file widths. Instruction and data memory sit outside the core on req/ack handshake ports, so wait-stated memories work. A run-control FSM (init/done) and a cycle counter are included. Decode, ALU and condition-code semantics follow the existing 9-bit htar9 ISA and the `definitions::alu_op_code` encoding unchanged.

## Interface
- `DW`, 8, datapath, register and data-address width
- `IW`, 16, PC / instruction-address width
- `RAW`, 3, register address width (2**RAW registers, r0 = accumulator)
- `CW`, 32, cycle counter width
- `clk`  in  1  clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `init`  in  1  start/restart request, sampled in IDLE or DONE only
- `done`  out  1  high while in DONE
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  IW  fetch address
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid same cycle
- `imem_rdata`  in  9  instruction word
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  DW  data address (ALU result)
- `dmem_wdata`  out  DW  store data (accumulator)
- `dmem_ack`  in  1  access complete; `dmem_rdata` valid same cycle on load
- `dmem_rdata`  in  DW  load data
- `cycle_count`  out  CW  clocks spent outside IDLE/DONE since last start

## Operation
- States: IDLE, FETCH, EXEC, MEM, DONE.
- IDLE: `init`=1 moves to FETCH with PC=0, cc=0, `cycle_count`=0.
- FETCH: `imem_req`=1, `imem_addr`=PC, both held stable until the transfer completes.
  - The transfer completes on an edge where `imem_req` & `imem_ack`.
  - On completion the word is latched into IR and the state moves to EXEC.
- EXEC:
  - The ALU evaluates with the operand mux rule: register operand if the decoder selects it, else `IR[5:0]` zero-extended to DW.
  - cc is updated from the ALU cc output.
  - Non-memory ops write back to the accumulator or to register `(2**RAW-1) - IR[RAW-1:0]`, per decoder.
  - PC update for non-memory ops:
    - Relative jump taken: PC += sign-extended 6-bit offset.
    - Absolute jump: PC = ALU result zero-extended to IW.
    - Otherwise: PC+1.
  - Load/store goes to MEM; halt goes to DONE; all other ops go to FETCH.
- MEM: `dmem_req`=1 with addr/we/wdata held stable until `dmem_ack`.
  - On completion a load writes `dmem_rdata` to the decoder-selected register.
  - PC+1, then FETCH.
- DONE: `done`=1; `init`=1 restarts exactly as from IDLE.
- Arithmetic: PC wraps modulo 2**IW. Register and ALU results are truncated to DW. `cycle_count` saturates at all-ones.
- `init` is ignored in FETCH/EXEC/MEM.
- `imem_ack` or `dmem_ack` without the matching req is ignored.
- `imem_req` and `dmem_req` are never high in the same cycle.

## Timing
- Reset (async, immediate) forces these values:
  - state IDLE, PC 0, IR 0, cc 0, all registers 0
  - `done` 0, `imem_req` 0, `dmem_req` 0, `dmem_we` 0, `imem_addr` 0, `dmem_addr` 0, `dmem_wdata` 0, `cycle_count` 0
- Reset mid-handshake drops req in the same cycle, and no write-back occurs.
- A combinational ack is allowed (zero-wait). Each extra wait cycle adds exactly 1 cycle.
- Zero-wait, no prefetch: ALU/branch op takes 2 cycles (FETCH, EXEC); load/store takes 3; halt takes 2, then `done` rises.
- A register written in EXEC/MEM is visible to the next instruction's EXEC.

## Configuration
- `HTAR9_MC_PREFETCH_EN` defined: adds a one-entry prefetch buffer.
  - During an EXEC that is not a memory op, the core issues `imem_req` for PC+1.
  - If the ack arrives in that cycle and no jump is taken, the core goes EXEC→EXEC on the buffered word: 1 cycle per sequential ALU op.
  - A taken jump, a halt, or a fetch not acked in EXEC discards or aborts the prefetch (req drops), and the core enters FETCH normally.
  - Memory ops never prefetch.
- `HTAR9_MC_PREFETCH_EN` undefined: no buffer, and `imem_req` is asserted only in FETCH.
- Architectural results are identical either way; only cycle counts differ.

## Test plan
- Zero-wait memories, program of 4 immediate adds then halt, no prefetch:
  - `done` rises 10 cycles after `init`.
  - accumulator = sum of immediates mod 2**DW.
  - `cycle_count`=10.
- Same program, prefetch on:
  - `done` after 6 cycles.
  - identical accumulator.
- Store 0x5A to addr 3, load addr 3 into r2, with `dmem_ack` delayed 2 cycles each:
  - `dmem_req` held 3 cycles per access with addr/wdata stable.
  - r2=0x5A.
- Relative jump with offset −2 taken at PC 0:
  - next `imem_addr`=2**IW−2 (wrap).
  - with prefetch, the PC+1 fetch is discarded.
- Assert `reset_n`=0 while `dmem_req`=1 on a store:
  - `dmem_req`=0 immediately.
  - all outputs at reset values.
  - no write occurs.
- `init` pulsed during EXEC: ignored. `init` in DONE: restarts at PC 0 with `cycle_count` cleared.

Source files
------------

// File: rtl/htar9_mc.sv
// htar9_mc: parametrised multicycle htar9 core with req/ack instruction and data memory ports.
// Optional feature: define HTAR9_MC_PREFETCH_EN for a one-entry instruction prefetch during EXEC.
module htar9_mc #(
    parameter int DW  = 8,
    parameter int IW  = 16,
    parameter int RAW = 3,
    parameter int CW  = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init,
    output logic          done,
    output logic          imem_req,
    output logic [IW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [8:0]    imem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [CW-1:0] cycle_count
);
    localparam int NREG = 2**RAW;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_PASS_A, ALU_PASS_B
    } alu_op_code;

    // Instruction word: IR[8:6] opcode, IR[5:0] immediate / offset / sub-op + register field.
    typedef enum logic [2:0] {
        OP_ADDI = 3'd0,
        OP_ANDI = 3'd1,
        OP_REG  = 3'd2,
        OP_LD   = 3'd3,
        OP_ST   = 3'd4,
        OP_JR   = 3'd5,
        OP_BNZ  = 3'd6,
        OP_SYS  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  pc;
    logic [8:0]     ir;
    logic           cc;
    logic [DW-1:0]  rf [NREG];
    logic [DW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;
    logic           mem_we_q;

    opcode_t        op;
    logic [RAW-1:0] reg_sel;
    alu_op_code     alu_op;
    logic           use_reg;
    logic           wb_acc;
    logic           wb_reg;
    logic           is_mem;
    logic           is_halt;
    logic           jump_abs;
    logic           jump_rel;
    logic           jump_taken;

    logic [DW-1:0]  opa;
    logic [DW-1:0]  opb;
    logic [DW-1:0]  alu_y;
    logic           alu_cc;

    logic [IW-1:0]  pc_inc;
    logic [IW-1:0]  rel_off;
    logic [IW-1:0]  pc_exec;
    logic           pf_req;
    logic           pf_hit;

    assign op      = opcode_t'(ir[8:6]);
    assign reg_sel = {RAW{1'b1}} - ir[RAW-1:0];

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        alu_op   = ALU_PASS_A;
        use_reg  = 1'b0;
        wb_acc   = 1'b0;
        wb_reg   = 1'b0;
        is_mem   = 1'b0;
        is_halt  = 1'b0;
        jump_abs = 1'b0;
        jump_rel = 1'b0;
        case (op)
            OP_ADDI: begin
                alu_op = ALU_ADD;
                wb_acc = 1'b1;
            end
            OP_ANDI: begin
                alu_op = ALU_AND;
                wb_acc = 1'b1;
            end
            OP_REG: begin
                use_reg = 1'b1;
                case (ir[5:4])
                    2'b00: begin alu_op = ALU_ADD;    wb_acc = 1'b1; end
                    2'b01: begin alu_op = ALU_SUB;    wb_acc = 1'b1; end
                    2'b10: begin alu_op = ALU_PASS_A; wb_reg = 1'b1; end
                    2'b11: begin alu_op = ALU_PASS_B; wb_acc = 1'b1; end
                endcase
            end
            OP_LD: begin
                alu_op = ALU_PASS_A;
                is_mem = 1'b1;
            end
            OP_ST: begin
                alu_op = ALU_PASS_B;
                is_mem = 1'b1;
            end
            OP_JR:  jump_rel = 1'b1;
            OP_BNZ: jump_rel = !cc;
            OP_SYS: begin
                if (ir[5]) is_halt  = 1'b1;
                else       jump_abs = 1'b1;
            end
            default: ;
        endcase
    end

    assign jump_taken = jump_abs || jump_rel;

    assign opa = rf[0];
    assign opb = use_reg ? rf[reg_sel] : DW'(ir[5:0]);

    // NOTE: blocking assignments in combinational logic; alu_y is read back below to form the flag.
    always_comb begin
        case (alu_op)
            ALU_ADD:    alu_y = opa + opb;
            ALU_SUB:    alu_y = opa - opb;
            ALU_AND:    alu_y = opa & opb;
            ALU_PASS_A: alu_y = opa;
            ALU_PASS_B: alu_y = opb;
            default:    alu_y = '0;
        endcase
        alu_cc = (alu_op inside {ALU_ADD, ALU_SUB, ALU_AND}) ? (alu_y == '0) : cc;
    end

    assign pc_inc  = pc + IW'(1);
    assign rel_off = {{(IW-6){ir[5]}}, ir[5:0]};

    always_comb begin
        if (jump_abs)      pc_exec = IW'(alu_y);
        else if (jump_rel) pc_exec = pc + rel_off;
        else               pc_exec = pc_inc;
    end

`ifdef HTAR9_MC_PREFETCH_EN
    assign pf_req = (state == S_EXEC) && !is_mem && !is_halt && !jump_taken;
`else
    assign pf_req = 1'b0;
`endif
    assign pf_hit = pf_req && imem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (init) state_nxt = S_FETCH;
            S_FETCH:        if (imem_ack) state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_mem)       state_nxt = S_MEM;
                else if (is_halt) state_nxt = S_DONE;
                else if (pf_hit)  state_nxt = S_EXEC;
                else              state_nxt = S_FETCH;
            end
            S_MEM:          if (dmem_ack) state_nxt = S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        done      = (state == S_DONE);
        imem_req  = (state == S_FETCH) || pf_req;
        imem_addr = pf_req ? pc_inc : pc;
        dmem_req  = (state == S_MEM);
        dmem_we   = (state == S_MEM) && mem_we_q;
    end

    assign dmem_addr  = mem_addr_q;
    assign dmem_wdata = mem_wdata_q;

    // NOTE: the register file is small and architecturally reset to zero, so it sits in the reset branch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= '0;
            ir          <= '0;
            cc          <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cycle_count <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (init) begin
                        pc          <= '0;
                        cc          <= 1'b0;
                        cycle_count <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) ir <= imem_rdata;
                end
                S_EXEC: begin
                    cc <= alu_cc;
                    if (is_mem) begin
                        mem_addr_q  <= alu_y;
                        mem_wdata_q <= rf[0];
                        mem_we_q    <= (op == OP_ST);
                    end else begin
                        pc <= pc_exec;
                        if (wb_acc) rf[0]       <= alu_y;
                        if (wb_reg) rf[reg_sel] <= alu_y;
                        if (pf_hit) ir          <= imem_rdata;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        pc <= pc_inc;
                        if (!mem_we_q) rf[reg_sel] <= dmem_rdata;
                    end
                end
                default: ;
            endcase
            if ((state inside {S_FETCH, S_EXEC, S_MEM}) && (cycle_count != '1))
                cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_htar9_mc.sv
// tb_htar9_mc: directed bench for htar9_mc with wait-stated memory models and fetch/data scoreboards.
module tb_htar9_mc;
    localparam int DW  = 8;
    localparam int IW  = 16;
    localparam int RAW = 3;
    localparam int CW  = 32;
`ifdef HTAR9_MC_PREFETCH_EN
    localparam int ADD_PROG_CYCLES = 6;
`else
    localparam int ADD_PROG_CYCLES = 10;
`endif

    localparam logic [2:0] OP_ADDI = 3'd0, OP_ANDI = 3'd1, OP_REG = 3'd2, OP_LD = 3'd3;
    localparam logic [2:0] OP_ST = 3'd4, OP_JR = 3'd5, OP_BNZ = 3'd6, OP_SYS = 3'd7;
    localparam logic [8:0] HALT = 9'h1E0;
    localparam logic [8:0] JMP  = 9'h1C0;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } mem_txn_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          init = 1'b0;
    logic          done;
    logic          imem_req;
    logic [IW-1:0] imem_addr;
    logic          imem_ack;
    logic [8:0]    imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic [CW-1:0] cycle_count;

    logic [8:0]    imem [64];
    logic [DW-1:0] dmem [2**DW];
    int            imem_wait = 0;
    int            dmem_wait = 0;
    int            icnt;
    int            dcnt;
    int            wr_count = 0;

    logic [IW-1:0] fetch_q [$];
    mem_txn_t      mem_q [$];
    int            errors = 0;
    int            checks = 0;

    htar9_mc #(.DW(DW), .IW(IW), .RAW(RAW), .CW(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .init        (init),
        .done        (done),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Memory models: ack after a programmable number of wait cycles, combinational when the wait is zero.
    assign imem_ack   = imem_req && (icnt == imem_wait);
    assign dmem_ack   = dmem_req && (dcnt == dmem_wait);
    assign imem_rdata = imem[imem_addr[5:0]];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (reset_n && dmem_req && dmem_ack && dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
            wr_count        <= wr_count + 1;
        end
    end

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [5:0] f);
        return {op, f};
    endfunction

    // Register fields name r[(2**RAW-1) - field]; sub-op in [5:4].
    function automatic logic [8:0] reg_op(input logic [1:0] sub, input int r);
        logic [2:0] f;
        f = 3'(7 - r);
        return {OP_REG, sub, 1'b0, f};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = HALT;
    endtask

    task automatic exp_fetch_range(input int first, input int count);
        for (int i = 0; i < count; i++) fetch_q.push_back(IW'(first + i));
    endtask

    task automatic exp_mem(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] data);
        mem_txn_t t;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        mem_q.push_back(t);
    endtask

    task automatic load_add4();
        clear_imem();
        imem[0] = enc(OP_ADDI, 6'd50);
        imem[1] = enc(OP_ADDI, 6'd60);
        imem[2] = enc(OP_ADDI, 6'd63);
        imem[3] = enc(OP_ADDI, 6'd40);
        imem[4] = HALT;
    endtask

    // Starts the core, monitors fetches and data accesses every cycle until done or budget expires.
    task automatic run_prog(input string tag, input int budget, input int exp_cycles, input int init_pulse_at);
        int            n;
        int            held;
        int            overlap;
        logic [DW-1:0] a0;
        logic [DW-1:0] d0;
        logic [IW-1:0] fa;
        mem_txn_t      t;
        held    = 0;
        overlap = 0;
        a0      = '0;
        d0      = '0;
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        n    = 0;
        check({tag, "_start_cycle_count"}, cycle_count, 0);
        check({tag, "_start_addr"}, imem_addr, 0);
        check({tag, "_start_req"}, imem_req, 1);
        while (!done && n < budget) begin
            init = (n == init_pulse_at);
            if (imem_req && dmem_req) overlap++;
            if (imem_req && imem_ack) begin
                check({tag, "_fetch_expected"}, fetch_q.size() > 0, 1);
                if (fetch_q.size() > 0) begin
                    fa = fetch_q.pop_front();
                    check({tag, "_fetch_addr"}, imem_addr, fa);
                end
            end
            if (dmem_req) begin
                if (held == 0) begin
                    a0 = dmem_addr;
                    d0 = dmem_wdata;
                end
                held++;
                if (dmem_ack) begin
                    check({tag, "_mem_expected"}, mem_q.size() > 0, 1);
                    if (mem_q.size() > 0) begin
                        t = mem_q.pop_front();
                        check({tag, "_mem_we"}, dmem_we, t.we);
                        check({tag, "_mem_addr_stable"}, {a0, dmem_addr}, {t.addr, t.addr});
                        if (t.we) check({tag, "_mem_wdata_stable"}, {d0, dmem_wdata}, {t.data, t.data});
                        check({tag, "_mem_req_cycles"}, held, dmem_wait + 1);
                    end
                    held = 0;
                end
            end
            @(negedge clk);
            n++;
        end
        init = 1'b0;
        check({tag, "_done"}, done, 1);
        if (exp_cycles >= 0) begin
            check({tag, "_latency"}, n, exp_cycles);
            check({tag, "_cycle_count"}, cycle_count, exp_cycles);
        end
        check({tag, "_fetch_drained"}, fetch_q.size(), 0);
        check({tag, "_mem_drained"}, mem_q.size(), 0);
        check({tag, "_req_overlap"}, overlap, 0);
    endtask

    initial begin
        int n;
        int wr_before;

        #3 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_dmem_addr_wdata", {dmem_addr, dmem_wdata}, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_acc", dut.rf[0], 0);
        reset_n = 1'b1;

        // Four immediate adds then halt, zero-wait memories.
        load_add4();
        exp_fetch_range(0, 5);
        run_prog("add4", 100, ADD_PROG_CYCLES, -1);
        check("add4_acc", dut.rf[0], 8'd213);

        // Same program again with init pulsed during EXEC: ignored; accumulator wraps mod 2**DW.
        exp_fetch_range(0, 5);
        run_prog("add4_init_exec", 100, ADD_PROG_CYCLES, 1);
        check("add4_acc_wrap", dut.rf[0], 8'd170);

        // Store 0x5A to 3, load 3 into r2, copy r2 to acc, store to 9; wait-stated memories.
        clear_imem();
        imem[0] = enc(OP_ANDI, 6'd0);
        imem[1] = enc(OP_ADDI, 6'd63);
        imem[2] = enc(OP_ADDI, 6'd27);
        imem[3] = enc(OP_ST, 6'd3);
        imem[4] = enc(OP_ANDI, 6'd0);
        imem[5] = enc(OP_ADDI, 6'd3);
        imem[6] = {OP_LD, 3'b000, 3'd5};
        imem[7] = reg_op(2'b11, 2);
        imem[8] = enc(OP_ST, 6'd9);
        imem[9] = HALT;
        imem_wait = 1;
        dmem_wait = 2;
        exp_fetch_range(0, 10);
        exp_mem(1'b1, 8'd3, 8'h5A);
        exp_mem(1'b0, 8'd3, 8'h00);
        exp_mem(1'b1, 8'd9, 8'h5A);
        run_prog("ldst", 300, -1, -1);
        check("ldst_r2", dut.rf[2], 8'h5A);
        check("ldst_acc", dut.rf[0], 8'h5A);

        // Register ops, conditional branches (taken / not taken) and absolute jump.
        clear_imem();
        imem[0]  = enc(OP_ANDI, 6'd0);
        imem[1]  = enc(OP_ADDI, 6'd5);
        imem[2]  = reg_op(2'b10, 1);
        imem[3]  = enc(OP_ADDI, 6'd2);
        imem[4]  = reg_op(2'b01, 1);
        imem[5]  = enc(OP_BNZ, 6'd3);
        imem[6]  = enc(OP_ST, 6'd20);
        imem[7]  = HALT;
        imem[8]  = enc(OP_ST, 6'd21);
        imem[9]  = reg_op(2'b01, 0);
        imem[10] = enc(OP_BNZ, 6'd5);
        imem[11] = enc(OP_ADDI, 6'd14);
        imem[12] = JMP;
        imem[13] = HALT;
        imem[14] = enc(OP_ST, 6'd22);
        imem[15] = HALT;
        imem_wait = 0;
        dmem_wait = 1;
        exp_fetch_range(0, 6);
        exp_fetch_range(8, 5);
        exp_fetch_range(14, 2);
        exp_mem(1'b1, 8'd21, 8'd2);
        exp_mem(1'b1, 8'd22, 8'd14);
        run_prog("branch", 300, -1, -1);
        check("branch_r1", dut.rf[1], 8'd5);

        // Relative jump of -2 at PC 0 wraps to 2**IW-2; no fetch of PC+1.
        clear_imem();
        imem[0] = enc(OP_JR, 6'h3E);
        dmem_wait = 0;
        fetch_q.push_back(IW'(0));
        fetch_q.push_back(16'hFFFE);
        run_prog("jr_wrap", 100, -1, -1);

        // Reset while a store is waiting for its ack.
        clear_imem();
        imem[0] = enc(OP_ANDI, 6'd0);
        imem[1] = enc(OP_ADDI, 6'd7);
        imem[2] = enc(OP_ST, 6'd5);
        dmem_wait = 3;
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        n = 0;
        while (!dmem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_store_reached", dmem_req, 1);
        check("rst_store_we", dmem_we, 1);
        wr_before = wr_count;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_dmem_req", dmem_req, 0);
        check("rst_mid_dmem_we", dmem_we, 0);
        check("rst_mid_imem", {imem_req, imem_addr}, 0);
        check("rst_mid_dmem_bus", {dmem_addr, dmem_wdata}, 0);
        check("rst_mid_done_cc", {done, cycle_count}, 0);
        check("rst_mid_acc", dut.rf[0], 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_no_write", wr_count, wr_before);
        check("rst_mid_idle_req", dmem_req, 0);

        // Recovery after reset: the add program runs from a cleared accumulator.
        dmem_wait = 0;
        load_add4();
        exp_fetch_range(0, 5);
        run_prog("add4_after_rst", 100, ADD_PROG_CYCLES, -1);
        check("add4_after_rst_acc", dut.rf[0], 8'd213);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
